// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C engine between NREQ requesters.
// Optional watchdog on the engine wait is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
  parameter int NREQ    = 3,
  parameter int NBYTES  = 3,
  parameter int NBW     = $clog2(NBYTES) + 1,
  parameter int TIMEOUT = 1000000
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*NBW-1:0]      nbytes_i,
  input  logic [NREQ*NBYTES*8-1:0] wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          ack_o,
  output logic [NBYTES*8-1:0]      rdata_o,
  output logic                     timeout_o,
  output logic                     busy_o,
  output logic                     eng_send_o,
  output logic [NBW-1:0]           eng_nbytes_o,
  output logic [NBYTES*8-1:0]      eng_data_o,
  input  logic                     eng_ready_i,
  input  logic                     eng_done_i,
  input  logic [NBYTES*8-1:0]      eng_rdata_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = NBYTES * 8;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, ACK, REL} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, ptr_nx, win, cand;
  logic            found;
  logic [NREQ-1:0] win_hot, gnt_nx, ack_nx;
  logic [DW-1:0]   rdata_nx, data_nx;
  logic [NBW-1:0]  nb_sel, nb_clamp, nbytes_nx;
  logic            send_nx, timeout_nx, expired;

  // Scan from the slot after the last winner so every requester gets a turn.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_hot  = NREQ'(1) << win;
  assign nb_sel   = nbytes_i[win*NBW +: NBW];
  assign nb_clamp = (nb_sel > NBW'(NBYTES)) ? NBW'(NBYTES) : nb_sel;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcount, tcount_nx;

  assign expired = (tcount == TW'(TIMEOUT - 1));

  always_comb begin
    tcount_nx = tcount;
    if (state == SEND)      tcount_nx = '0;
    else if (state == WAIT) tcount_nx = tcount + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tcount <= '0;
    else          tcount <= tcount_nx;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    gnt_nx     = gnt_o;
    ack_nx     = '0;
    rdata_nx   = rdata_o;
    data_nx    = eng_data_o;
    nbytes_nx  = eng_nbytes_o;
    send_nx    = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (found && eng_ready_i) begin
          gnt_nx    = win_hot;
          ptr_nx    = win;
          nbytes_nx = nb_clamp;
          data_nx   = wdata_i[win*DW +: DW];
          // Zero-length requests complete without touching the engine.
          if (nb_clamp == '0) begin
            ack_nx   = win_hot;
            state_nx = ACK;
          end else begin
            send_nx  = 1'b1;
            state_nx = SEND;
          end
        end
      end
      SEND: state_nx = WAIT;
      WAIT: begin
        if (eng_done_i) begin
          rdata_nx = eng_rdata_i;
          ack_nx   = gnt_o;
          state_nx = ACK;
        end else if (expired) begin
          timeout_nx = 1'b1;
          ack_nx     = gnt_o;
          state_nx   = ACK;
        end
      end
      ACK: begin
        gnt_nx   = '0;
        state_nx = REL;
      end
      REL: if (eng_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      ptr          <= PW'(NREQ - 1);
      gnt_o        <= '0;
      ack_o        <= '0;
      rdata_o      <= '0;
      timeout_o    <= 1'b0;
      busy_o       <= 1'b0;
      eng_send_o   <= 1'b0;
      eng_nbytes_o <= '0;
      eng_data_o   <= '0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      gnt_o        <= gnt_nx;
      ack_o        <= ack_nx;
      rdata_o      <= rdata_nx;
      timeout_o    <= timeout_nx;
      busy_o       <= (state_nx != IDLE);
      eng_send_o   <= send_nx;
      eng_nbytes_o <= nbytes_nx;
      eng_data_o   <= data_nx;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed cases plus random transactions
// compared against a transaction-level round-robin model; the bench also plays the engine.
module tb_i2c_arbiter;

  localparam int NREQ   = 3;
  localparam int NBYTES = 3;
  localparam int NBW    = 3;
  localparam int DW     = 24;

  logic                clk_i = 1'b0;
  logic                rst_n_i = 1'b0;
  logic [NREQ-1:0]     req_i = '0;
  logic [NREQ*NBW-1:0] nbytes_i = '0;
  logic [NREQ*DW-1:0]  wdata_i = '0;
  logic [NREQ-1:0]     gnt_o, ack_o;
  logic [DW-1:0]       rdata_o;
  logic                timeout_o, busy_o, eng_send_o;
  logic [NBW-1:0]      eng_nbytes_o;
  logic [DW-1:0]       eng_data_o;
  logic                eng_ready_i = 1'b1;
  logic                eng_done_i = 1'b0;
  logic [DW-1:0]       eng_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  int last_win = NREQ - 1;
  logic [DW-1:0] exp_rdata = '0;

  always #5 clk_i = ~clk_i;

  i2c_arbiter #(.NREQ(NREQ), .NBYTES(NBYTES), .NBW(NBW), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .nbytes_i(nbytes_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o),
    .timeout_o(timeout_o), .busy_o(busy_o), .eng_send_o(eng_send_o),
    .eng_nbytes_o(eng_nbytes_o), .eng_data_o(eng_data_o),
    .eng_ready_i(eng_ready_i), .eng_done_i(eng_done_i), .eng_rdata_i(eng_rdata_i)
  );

  task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester found scanning upward from last winner + 1.
  function automatic int rr_pick(input logic [NREQ-1:0] req, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_gnt"}, gnt_o, 0);
    check_output({tag, "_ack"}, ack_o, 0);
    check_output({tag, "_rdata"}, rdata_o, 0);
    check_output({tag, "_timeout"}, timeout_o, 0);
    check_output({tag, "_busy"}, busy_o, 0);
    check_output({tag, "_send"}, eng_send_o, 0);
    check_output({tag, "_nbytes"}, eng_nbytes_o, 0);
    check_output({tag, "_data"}, eng_data_o, 0);
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (gnt_o !== '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_output("grant_wait", 0, 1);
  endtask

  // One full transaction: present requests, act as the engine, check every stage.
  task automatic apply_stimulus(input logic [NREQ-1:0] req, input logic [NREQ*NBW-1:0] nb,
                                input logic [NREQ*DW-1:0] wd, input int lat, input logic [DW-1:0] rd);
    int w, n_exp;
    bit got;
    logic [NREQ-1:0] hot;
    req_i = req;
    nbytes_i = nb;
    wdata_i = wd;
    eng_ready_i = 1'b1;
    w = rr_pick(req, last_win);
    n_exp = int'(nb[w*NBW +: NBW]);
    if (n_exp > NBYTES) n_exp = NBYTES;
    hot = NREQ'(1) << w;
    wait_grant(got);
    if (!got) begin
      req_i = '0;
      return;
    end
    last_win = w;
    check_output("gnt", gnt_o, hot);
    check_output("busy", busy_o, 1);
    check_output("eng_nbytes", eng_nbytes_o, n_exp);
    check_output("eng_data", eng_data_o, wd[w*DW +: DW]);
    if (n_exp == 0) begin
      check_output("zero_len_send", eng_send_o, 0);
      check_output("zero_len_ack", ack_o, hot);
      check_output("zero_len_rdata", rdata_o, exp_rdata);
    end else begin
      check_output("send_high", eng_send_o, 1);
      @(negedge clk_i);
      check_output("send_pulse", eng_send_o, 0);
      for (int i = 0; i < lat; i++) begin
        check_output("ack_early", ack_o, 0);
        @(negedge clk_i);
      end
      eng_done_i = 1'b1;
      eng_rdata_i = rd;
      @(negedge clk_i);
      eng_done_i = 1'b0;
      exp_rdata = rd;
      check_output("ack", ack_o, hot);
      check_output("rdata", rdata_o, exp_rdata);
    end
    req_i = '0;
    @(negedge clk_i);
    check_output("ack_one_cycle", ack_o, 0);
    check_output("gnt_release", gnt_o, 0);
  endtask

  initial begin
    bit got;
    logic [NREQ*NBW-1:0] nb;
    logic [NREQ*DW-1:0]  wd;

    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] basic transfer");
    apply_stimulus(3'b001, {3'd0, 3'd0, 3'd2}, {24'h0, 24'h0, 24'hA01234}, 3, 24'h0055AA);

    $display("[TB] byte-count edge cases");
    apply_stimulus(3'b010, {3'd0, 3'd0, 3'd0}, {24'h0, 24'hBEEF01, 24'h0}, 0, 24'h0);
    apply_stimulus(3'b100, {3'd5, 3'd0, 3'd0}, {24'hC0FFEE, 24'h0, 24'h0}, 1, 24'h123456);

    $display("[TB] engine not ready");
    eng_ready_i = 1'b0;
    req_i = 3'b001;
    nbytes_i = {3'd0, 3'd0, 3'd1};
    repeat (5) begin
      @(negedge clk_i);
      check_output("stall_gnt", gnt_o, 0);
      check_output("stall_send", eng_send_o, 0);
    end
    eng_done_i = 1'b1;
    @(negedge clk_i);
    eng_done_i = 1'b0;
    check_output("idle_done_ack", ack_o, 0);
    apply_stimulus(3'b001, {3'd0, 3'd0, 3'd1}, {24'h0, 24'h0, 24'h00005A}, 2, 24'hABCDEF);

    $display("[TB] reset during wait");
    req_i = 3'b010;
    nbytes_i = {3'd0, 3'd2, 3'd0};
    wdata_i = {24'h0, 24'h777777, 24'h0};
    wait_grant(got);
    repeat (2) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1 check_all_zero("async_reset");
    req_i = '0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    last_win = NREQ - 1;
    exp_rdata = '0;
    eng_done_i = 1'b1;
    @(negedge clk_i);
    eng_done_i = 1'b0;
    @(negedge clk_i);
    check_output("post_reset_done_ack", ack_o, 0);

    $display("[TB] round-robin with all requesting");
    for (int i = 0; i < 6; i++) begin
      nb = {3'($urandom_range(1, 3)), 3'($urandom_range(1, 3)), 3'($urandom_range(1, 3))};
      wd = {24'($urandom), 24'($urandom), 24'($urandom)};
      apply_stimulus(3'b111, nb, wd, $urandom_range(0, 3), 24'($urandom));
      check_output("rr_order", gnt_o === '0 ? last_win : -1, i % NREQ);
    end

    $display("[TB] random transactions");
    for (int i = 0; i < 30; i++) begin
      nb = {3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5))};
      wd = {24'($urandom), 24'($urandom), 24'($urandom)};
      apply_stimulus(3'($urandom_range(1, 7)), nb, wd, $urandom_range(0, 6), 24'($urandom));
    end

`ifdef I2C_ARB_TIMEOUT_EN
    $display("[TB] watchdog");
    req_i = 3'b001;
    nbytes_i = {3'd0, 3'd0, 3'd1};
    wait_grant(got);
    last_win = 0;
    @(negedge clk_i);
    for (int i = 0; i < 16; i++) begin
      check_output("wd_timeout_early", timeout_o, 0);
      check_output("wd_ack_early", ack_o, 0);
      @(negedge clk_i);
    end
    check_output("wd_timeout", timeout_o, 1);
    check_output("wd_ack", ack_o, 3'b001);
    check_output("wd_rdata", rdata_o, exp_rdata);
    req_i = '0;
    eng_ready_i = 1'b0;
    @(negedge clk_i);
    check_output("wd_timeout_pulse", timeout_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      check_output("wd_rel_busy", busy_o, 1);
    end
    eng_ready_i = 1'b1;
    @(negedge clk_i);
    check_output("wd_idle", busy_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Shares one byte-level I2C engine between NREQ independent requesters, e.g. the ROM-driven HDMI init sequencer, runtime register writes and the EDID/status poller.
- Uses round-robin arbitration.
- Latches the winner's byte count and payload, issues a single-cycle send, waits for engine completion and returns a per-requester ack plus the engine's read data.
- Sits between the requesters and the engine's send/nbytes/data/done/ready interface.

Parameters:
- NREQ, 3, number of requesters (2..8).
- NBYTES, 3, maximum bytes per I2C transaction.
- NBW, $clog2(NBYTES)+1, width of byte-count fields.
- TIMEOUT, 1000000, watchdog limit in clk_i cycles; used only with I2C_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_i  in  NREQ  per-requester request level.
- nbytes_i  in  NREQ*NBW  per-requester byte count; slice k = [k*NBW +: NBW].
- wdata_i  in  NREQ*NBYTES*8  per-requester payload; slice k = [k*NBYTES*8 +: NBYTES*8].
- gnt_o  out  NREQ  one-hot, the requester currently owning the engine.
- ack_o  out  NREQ  one-cycle completion pulse to the owner.
- rdata_o  out  NBYTES*8  engine read data captured at completion.
- timeout_o  out  1  one-cycle pulse on watchdog abort.
- busy_o  out  1  high whenever state is not IDLE.
- eng_send_o  out  1  one-cycle start to the engine.
- eng_nbytes_o  out  NBW  latched byte count to the engine.
- eng_data_o  out  NBYTES*8  latched payload to the engine.
- eng_ready_i  in  1  engine idle.
- eng_done_i  in  1  engine transaction-complete pulse.
- eng_rdata_i  in  NBYTES*8  engine read data.

Behaviour:
- Single clock clk_i; asynchronous active-low reset rst_n_i.
- All outputs are registered.
- Reset values:
  - gnt_o, ack_o, rdata_o, timeout_o, busy_o, eng_send_o, eng_nbytes_o, eng_data_o = 0.
  - state = IDLE.
  - last-winner pointer = NREQ-1, so requester 0 wins first.
- Reset mid-transaction aborts immediately. The engine is not notified; it finishes alone, and any eng_done_i arriving in IDLE is ignored.

States IDLE, SEND, WAIT, ACK, REL:
- IDLE: when |req_i and eng_ready_i are both high:
  - Pick the first asserted request scanning from pointer+1 modulo NREQ.
  - Set gnt_o one-hot and pointer = winner.
  - Latch eng_nbytes_o and eng_data_o.
  - If nbytes > NBYTES, latch NBYTES instead.
  - nbytes == 0: go to ACK without an engine transaction; rdata_o is unchanged.
  - Otherwise assert eng_send_o for exactly one cycle and go to SEND.
- SEND: deassert eng_send_o; go to WAIT.
- WAIT:
  - On eng_done_i: rdata_o <= eng_rdata_i, ack_o[winner] <= 1, go to ACK.
  - eng_done_i outside WAIT is ignored.
- ACK: ack_o cleared, so the pulse lasts one cycle. gnt_o cleared; go to REL.
- REL: wait for eng_ready_i = 1, then go to IDLE.
- Latency:
  - req_i sampled in IDLE at cycle N gives eng_send_o high at N+1.
  - eng_done_i at cycle M gives ack_o at M+1.
  - Minimum re-arbitration gap is 2 cycles after ack_o.
- Requester rules:
  - Hold nbytes_i and wdata_i stable from the req_i rise until the first cycle gnt_o is high; they are latched then.
  - Drop req_i in the cycle after ack_o. A still-high req_i counts as a new request, and other pending requesters win first under round-robin.
  - Dropping req_i while granted does not abort; the transaction completes and ack_o still pulses.
- Simultaneous requests: round-robin only, with no fixed priority.
- An eng_ready_i low in IDLE stalls arbitration.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT before eng_done_i: timeout_o and ack_o[winner] pulse together for one cycle, rdata_o is unchanged, go to ACK.
  - An eng_done_i in the same cycle as the limit takes priority; this counts as a normal completion with no timeout.
- Disabled: no counter; WAIT lasts until eng_done_i; timeout_o is tied 0.

Test Plan:
- Reset, then req_i=3'b001, nbytes=2, wdata=24'hA0_1234 (NREQ=3, NBYTES=3) -> eng_send_o high for one cycle 1 cycle after req_i is sampled; eng_nbytes_o=2; eng_data_o=24'hA01234; done with eng_rdata_i=24'h00_55AA -> ack_o=3'b001 one cycle later, rdata_o=24'h0055AA.
- req_i=3'b111 held and re-asserted after every ack_o -> grant order 0,1,2,0,1,2; no requester is granted twice in a row while others are pending.
- nbytes_i=0 on requester 1 -> ack_o=3'b010 with no eng_send_o pulse; nbytes_i=5 -> eng_nbytes_o=3.
- eng_ready_i=0 with req_i pending -> no grant and no send until eng_ready_i=1; eng_done_i pulsed in IDLE -> no ack_o.
- rst_n_i asserted low asynchronously mid-WAIT -> all outputs 0 immediately; after release, requester 0 wins first.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT=16, eng_done_i withheld -> timeout_o and ack_o[winner] pulse 16 cycles after WAIT entry; then REL, then IDLE once eng_ready_i=1.
